// File: rtl/cache_controller.sv
`default_nettype none
// ============================================================================
// Module      : cache_controller
// Description : Direct-mapped, write-back, write-allocate cache controller
//               sequencing external data/tag memories and a main-memory port.
//               Optional hit/miss/write-back counters: CACHE_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_controller #(
    parameter int ADDR_W   = 32,
    parameter int OFFSET_W = 2,
    parameter int IDX_W    = 5,
    parameter int DATA_W   = 32,
    parameter int TAG_W    = ADDR_W - IDX_W - OFFSET_W
) (
    input  logic                iCLK,
    input  logic                iRST_n,
    input  logic                cpu_req,
    input  logic                cpu_we,
    input  logic [ADDR_W-1:0]   cpu_addr,
    input  logic [DATA_W-1:0]   cpu_wdata,
    output logic [DATA_W-1:0]   cpu_rdata,
    output logic                cpu_ready,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_ready,
    output logic [IDX_W-1:0]    idx,
    output logic                data_we,
    output logic [DATA_W-1:0]   data_block_in,
    input  logic [DATA_W-1:0]   data_block_out,
    output logic                tag_we,
    output logic [TAG_W+1:0]    tag_block_in,
    input  logic [TAG_W+1:0]    tag_block_out
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0]         hit_count,
    output logic [31:0]         miss_count,
    output logic [31:0]         wb_count
`endif
);

    typedef enum logic [2:0] {
        S_INIT      = 3'd0,
        S_IDLE      = 3'd1,
        S_COMPARE   = 3'd2,
        S_WRITEBACK = 3'd3,
        S_ALLOCATE  = 3'd4
    } state_t;

    localparam logic [IDX_W-1:0] c_last_idx = {IDX_W{1'b1}};

    state_t              r_state;
    state_t              w_state_next;
    logic [IDX_W-1:0]    r_init_cnt;
    logic [IDX_W-1:0]    r_idx;
    logic [TAG_W-1:0]    r_tag;
    logic                r_we;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_rdata;

    logic                w_valid;
    logic                w_dirty;
    logic [TAG_W-1:0]    w_stored_tag;
    logic                w_hit;
    logic                w_unused_offset;

    assign w_valid         = tag_block_out[TAG_W+1];
    assign w_dirty         = tag_block_out[TAG_W];
    assign w_stored_tag    = tag_block_out[TAG_W-1:0];
    assign w_hit           = w_valid && (w_stored_tag == r_tag);
    assign w_unused_offset = ^cpu_addr[OFFSET_W-1:0];
    assign cpu_rdata       = r_rdata;

    always_comb begin
        w_state_next  = r_state;
        idx           = r_idx;
        data_we       = 1'b0;
        data_block_in = r_wdata;
        tag_we        = 1'b0;
        tag_block_in  = '0;
        cpu_ready     = 1'b0;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        mem_addr      = '0;
        mem_wdata     = '0;
        case (r_state)
            S_INIT: begin
                idx    = r_init_cnt;
                // Held off while reset is asserted so the sweep is exactly one pass after release
                tag_we = iRST_n;
                if (r_init_cnt == c_last_idx) begin
                    w_state_next = S_IDLE;
                end
            end
            S_IDLE: begin
                if (cpu_req) begin
                    w_state_next = S_COMPARE;
                end
            end
            S_COMPARE: begin
                if (w_hit) begin
                    cpu_ready    = 1'b1;
                    w_state_next = S_IDLE;
                    if (r_we) begin
                        data_we      = 1'b1;
                        tag_we       = 1'b1;
                        tag_block_in = {1'b1, 1'b1, r_tag};
                    end
                end else if (w_valid && w_dirty) begin
                    w_state_next = S_WRITEBACK;
                end else begin
                    w_state_next = S_ALLOCATE;
                end
            end
            S_WRITEBACK: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {w_stored_tag, r_idx, {OFFSET_W{1'b0}}};
                mem_wdata = data_block_out;
                if (mem_ready) begin
                    w_state_next = S_ALLOCATE;
                end
            end
            S_ALLOCATE: begin
                mem_req  = 1'b1;
                mem_addr = {r_tag, r_idx, {OFFSET_W{1'b0}}};
                if (mem_ready) begin
                    data_we       = 1'b1;
                    data_block_in = mem_rdata;
                    tag_we        = 1'b1;
                    tag_block_in  = {1'b1, 1'b0, r_tag};
                    w_state_next  = S_COMPARE;
                end
            end
            default: begin
                w_state_next = S_INIT;
            end
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (!iRST_n) begin
            r_state    <= S_INIT;
            r_init_cnt <= '0;
            r_idx      <= '0;
            r_tag      <= '0;
            r_we       <= 1'b0;
            r_wdata    <= '0;
            r_rdata    <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == S_INIT) begin
                r_init_cnt <= r_init_cnt + 1'b1;
            end
            if (r_state == S_IDLE && cpu_req) begin
                r_idx   <= cpu_addr[OFFSET_W +: IDX_W];
                r_tag   <= cpu_addr[ADDR_W-1 -: TAG_W];
                r_we    <= cpu_we;
                r_wdata <= cpu_wdata;
            end
            if (r_state == S_COMPARE && w_hit && !r_we) begin
                r_rdata <= data_block_out;
            end
        end
    end

`ifdef CACHE_STATS_EN
    // Marks the first COMPARE of a request so the post-refill re-compare is not counted
    logic r_first;

    always_ff @(posedge iCLK) begin
        if (!iRST_n) begin
            r_first    <= 1'b0;
            hit_count  <= '0;
            miss_count <= '0;
            wb_count   <= '0;
        end else begin
            if (r_state == S_IDLE && cpu_req) begin
                r_first <= 1'b1;
            end else if (r_state == S_COMPARE) begin
                r_first <= 1'b0;
            end
            if (r_state == S_COMPARE && r_first) begin
                if (w_hit) begin
                    hit_count <= hit_count + 32'd1;
                end else begin
                    miss_count <= miss_count + 32'd1;
                end
            end
            if (r_state == S_WRITEBACK && mem_ready) begin
                wb_count <= wb_count + 32'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_cache_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_cache_controller
// Description : Scoreboard bench for cache_controller with data/tag memory
//               and main-memory models.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_controller;

    localparam int c_lat = 3;

    logic        iCLK;
    logic        iRST_n;
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_ready;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic [4:0]  idx;
    logic        data_we;
    logic [31:0] data_block_in;
    logic [31:0] data_block_out;
    logic        tag_we;
    logic [26:0] tag_block_in;
    logic [26:0] tag_block_out;
`ifdef CACHE_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
    logic [31:0] wb_count;
`endif

    cache_controller u_dut (
        .iCLK           (iCLK),
        .iRST_n         (iRST_n),
        .cpu_req        (cpu_req),
        .cpu_we         (cpu_we),
        .cpu_addr       (cpu_addr),
        .cpu_wdata      (cpu_wdata),
        .cpu_rdata      (cpu_rdata),
        .cpu_ready      (cpu_ready),
        .mem_req        (mem_req),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .mem_ready      (mem_ready),
        .idx            (idx),
        .data_we        (data_we),
        .data_block_in  (data_block_in),
        .data_block_out (data_block_out),
        .tag_we         (tag_we),
        .tag_block_in   (tag_block_in),
        .tag_block_out  (tag_block_out)
`ifdef CACHE_STATS_EN
        ,
        .hit_count      (hit_count),
        .miss_count     (miss_count),
        .wb_count       (wb_count)
`endif
    );

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_op_t;

    mem_op_t     mem_q[$];
    logic [31:0] rd_q[$];
    logic [31:0] main_mem [logic [31:0]];
    logic [31:0] dmem [32];
    logic [26:0] tmem [32];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          mcnt = 0;

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    always @(posedge iCLK) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        if (main_mem.exists(a)) return main_mem[a];
        return a ^ 32'h5A5A_5A5A;
    endfunction

    // Data/tag memories: combinational read, clocked write; reset fills stale valid lines
    assign data_block_out = dmem[idx];
    assign tag_block_out  = tmem[idx];
    always @(posedge iCLK) begin
        if (!iRST_n) begin
            for (int i = 0; i < 32; i++) tmem[i] <= {1'b1, 1'b0, 25'd0};
        end else begin
            if (data_we) dmem[idx] <= data_block_in;
            if (tag_we)  tmem[idx] <= tag_block_in;
        end
    end

    // Main memory responder: ready pulse c_lat cycles into each request
    always @(negedge iCLK) begin
        mem_op_t e;
        if (!iRST_n) begin
            mem_ready = 1'b0;
            mcnt = 0;
        end else if (mem_ready) begin
            mem_ready = 1'b0;
            mcnt = 0;
        end else if (mem_req) begin
            mcnt++;
            if (mcnt == c_lat) begin
                check("mem_expected", 64'(mem_q.size() != 0), 64'(1));
                if (mem_q.size() != 0) begin
                    e = mem_q.pop_front();
                    check("mem_we", 64'(mem_we), 64'(e.we));
                    check("mem_addr", 64'(mem_addr), 64'(e.addr));
                    if (e.we) check("mem_wdata", 64'(mem_wdata), 64'(e.wdata));
                end
                if (mem_we) main_mem[mem_addr] = mem_wdata;
                else mem_rdata = mem_val(mem_addr);
                mem_ready = 1'b1;
            end
        end
    end

    task automatic wait_done(input int start, input int exp_edges, input string tag);
        bit got = 0;
        bit saw_mem = 0;
        logic [31:0] exp;
        for (int k = 0; k < 300 && !got; k++) begin
            @(negedge iCLK);
            if (mem_req) saw_mem = 1;
            if (cpu_ready) got = 1;
        end
        check({tag, "_ready"}, 64'(got), 64'(1));
        if (got) begin
            @(posedge iCLK);
            #1;
            if (exp_edges > 0) check({tag, "_latency"}, 64'(cyc - start), 64'(exp_edges));
            if (exp_edges == 2) check({tag, "_no_mem"}, 64'(saw_mem), 64'(0));
            if (!cpu_we && rd_q.size() != 0) begin
                exp = rd_q.pop_front();
                check({tag, "_rdata"}, 64'(cpu_rdata), 64'(exp));
            end
            check({tag, "_mem_done"}, 64'(mem_q.size()), 64'(0));
        end
        cpu_req = 1'b0;
    endtask

    task automatic access(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata, input int exp_edges, input string tag);
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        if (!we) rd_q.push_back(exp_rdata);
        wait_done(cyc, exp_edges, tag);
    endtask

    initial begin
        int start;
        iRST_n    = 1'b0;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        main_mem[32'h40] = 32'hDEADBEEF;
        repeat (3) @(negedge iCLK);
        check("rst_cpu_ready", 64'(cpu_ready), 64'(0));
        check("rst_cpu_rdata", 64'(cpu_rdata), 64'(0));
        check("rst_mem_req", 64'(mem_req), 64'(0));
        check("rst_mem_addr", 64'(mem_addr), 64'(0));
        check("rst_data_we", 64'(data_we), 64'(0));
        check("rst_tag_we", 64'(tag_we), 64'(0));

        // Cold load held across INIT
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 32'h40;
        rd_q.push_back(32'hDEADBEEF);
        mem_q.push_back('{1'b0, 32'h40, 32'h0});
        iRST_n = 1'b1;
        start  = cyc;
        for (int i = 0; i < 32; i++) begin
            #1;
            check("init_tag_we", 64'(tag_we), 64'(1));
            check("init_idx", 64'(idx), 64'(i));
            check("init_tag_in", 64'(tag_block_in), 64'(0));
            check("init_no_ack", 64'(cpu_ready), 64'(0));
            @(negedge iCLK);
        end
        check("init_end", 64'(tag_we), 64'(0));
        wait_done(start, 32 + 6, "cold");

        access(1'b0, 32'h40, 32'h0, 32'hDEADBEEF, 2, "hit");
        access(1'b1, 32'h40, 32'h12345678, 32'h0, 2, "st_hit");
        check("st_hit_data", 64'(dmem[16]), 64'(32'h12345678));
        check("st_hit_tag", 64'(tmem[16]), 64'({2'b11, 25'd0}));
        access(1'b0, 32'h40, 32'h0, 32'h12345678, 2, "ld_after_st");

        mem_q.push_back('{1'b1, 32'h40, 32'h12345678});
        mem_q.push_back('{1'b0, 32'hC0, 32'h0});
        access(1'b0, 32'hC0, 32'h0, mem_val(32'hC0), 0, "dirty_miss");
        access(1'b0, 32'hC3, 32'h0, mem_val(32'hC0), 2, "offset_hit");

        mem_q.push_back('{1'b0, 32'h84, 32'h0});
        access(1'b1, 32'h84, 32'hCAFEF00D, 32'h0, 6, "st_miss");
        check("st_miss_data", 64'(dmem[1]), 64'(32'hCAFEF00D));
        check("st_miss_tag", 64'(tmem[1]), 64'({2'b11, 25'd1}));
        mem_q.push_back('{1'b1, 32'h84, 32'hCAFEF00D});
        mem_q.push_back('{1'b0, 32'h04, 32'h0});
        access(1'b0, 32'h04, 32'h0, mem_val(32'h04), 0, "conflict");
        mem_q.push_back('{1'b0, 32'h84, 32'h0});
        access(1'b0, 32'h84, 32'h0, 32'hCAFEF00D, 6, "wb_landed");

        // Reset during ALLOCATE
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 32'h140;
        for (int k = 0; k < 50 && !mem_req; k++) @(negedge iCLK);
        check("abort_req_seen", 64'(mem_req), 64'(1));
        check("abort_is_refill", 64'(mem_we), 64'(0));
        iRST_n = 1'b0;
        @(posedge iCLK);
        #1;
        check("abort_req_drop", 64'(mem_req), 64'(0));
        cpu_req = 1'b0;
        repeat (2) @(negedge iCLK);
        iRST_n = 1'b1;
        repeat (34) @(negedge iCLK);
        @(posedge iCLK);
        #1;
        mem_q.push_back('{1'b0, 32'h40, 32'h0});
        access(1'b0, 32'h40, 32'h0, 32'h12345678, 6, "post_rst_miss");
        access(1'b0, 32'h40, 32'h0, 32'h12345678, 2, "post_rst_hit");
`ifdef CACHE_STATS_EN
        check("stat_hit", 64'(hit_count), 64'(1));
        check("stat_miss", 64'(miss_count), 64'(1));
        check("stat_wb", 64'(wb_count), 64'(0));
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200_000;
        $display("FAIL watchdog expired got=timeout exp=finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
